tx_frame_arbiter: RTL and testbench

//  Parametrised N-source frame arbiter for the host TX path; successor to the fixed 3-source tx multiplexer.

---
 rtl/tx_frame_arbiter.sv | 136 +++++++++++++
 tb/tb_tx_frame_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// N-source frame arbiter for the host TX path: one grant per frame (held until eof),
// fixed-priority or round-robin, optional per-frame source-tag header, stall-timeout abort.
module tx_frame_arbiter #(
  parameter int unsigned                  DATA_WIDTH  = 8,
  parameter int unsigned                  SOURCES     = 3,
  parameter int unsigned                  ARB_MODE    = 0,
  parameter int unsigned                  HEADER_EN   = 1,
  parameter logic [DATA_WIDTH-1:0]        HEADER_BASE = DATA_WIDTH'('hA0),
  parameter int unsigned                  TIMEOUT     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SOURCES*DATA_WIDTH-1:0]   src_data,
  input  logic [SOURCES-1:0]              src_rdy,
  input  logic [SOURCES-1:0]              src_eof,
  output logic [SOURCES-1:0]              src_ack,
  input  logic [SOURCES-1:0]              src_en,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            tx_rdy,
  input  logic                            tx_ack,
  output logic [SOURCES-1:0]              grant_o,
  output logic                            busy,
  output logic                            frame_abort
);

  localparam int unsigned IW = $clog2(SOURCES);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_STREAM} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   stall_q, stall_d;
  logic            abort_q, abort_d;

  logic [SOURCES-1:0]    req;
  logic [IW-1:0]         win;
  logic                  win_vld;
  logic [IW-1:0]         next_ptr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  cur_rdy;
  logic                  cur_eof;

  // Candidate order is rotated by the rr pointer in round-robin mode; first requester wins.
  always_comb begin
    int unsigned j;
    j       = 0;
    req     = src_rdy & src_en;
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned k = 0; k < SOURCES; k++) begin
      if (ARB_MODE == 0) j = k;
      else               j = (32'(ptr_q) + k) % SOURCES;
      if (!win_vld && req[j]) begin
        win     = IW'(j);
        win_vld = 1'b1;
      end
    end
  end

  assign cur_data = src_data[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign cur_rdy  = src_rdy[idx_q];
  assign cur_eof  = src_eof[idx_q];
  assign next_ptr = (idx_q == IW'(SOURCES - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    stall_d = stall_q;
    abort_d = 1'b0;
    tx_rdy  = 1'b0;
    tx_data = '0;
    src_ack = '0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          idx_d   = win;
          stall_d = '0;
          state_d = (HEADER_EN != 0) ? S_HEADER : S_STREAM;
        end
      end
      S_HEADER: begin
        tx_rdy  = 1'b1;
        tx_data = HEADER_BASE + DATA_WIDTH'(idx_q);
        if (tx_ack) begin
          state_d = S_STREAM;
          stall_d = '0;
        end
      end
      S_STREAM: begin
        tx_rdy         = cur_rdy;
        tx_data        = cur_data;
        src_ack[idx_q] = tx_ack & cur_rdy;
        if (cur_rdy) begin
          stall_d = '0;
          if (tx_ack && cur_eof) begin
            state_d = S_IDLE;
            ptr_d   = next_ptr;
          end
        end else if (TIMEOUT != 0) begin
          // Abort fires on the cycle the count reaches TIMEOUT; saturate in case it lingers.
          if (stall_q != CW'(TIMEOUT)) stall_d = stall_q + 1'b1;
          if (32'(stall_q) + 1 >= TIMEOUT) begin
            state_d = S_IDLE;
            ptr_d   = next_ptr;
            abort_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end

  assign grant_o     = (state_q == S_IDLE) ? '0 : (SOURCES'(1) << idx_q);
  assign busy        = (state_q != S_IDLE);
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: DUT A (fixed priority, header, timeout 16) and
// DUT B (round-robin, no header, timeout 16) checked every cycle against a frame-rule model.
module tb_tx_frame_arbiter;

  localparam int W  = 8;
  localparam int S  = 3;
  localparam int ND = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [S*W-1:0] sd    [ND];
  logic [S-1:0]   srdy  [ND];
  logic [S-1:0]   seof  [ND];
  logic [S-1:0]   sack  [ND];
  logic [S-1:0]   sen   [ND];
  logic [S-1:0]   grant [ND];
  logic [W-1:0]   tdata [ND];
  logic           trdy  [ND];
  logic           tack  [ND];
  logic           busy  [ND];
  logic           abort [ND];

  tx_frame_arbiter #(.DATA_WIDTH(8), .SOURCES(3), .ARB_MODE(0), .HEADER_EN(1),
                     .HEADER_BASE(8'hA0), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst_n), .src_data(sd[0]), .src_rdy(srdy[0]), .src_eof(seof[0]),
    .src_ack(sack[0]), .src_en(sen[0]), .tx_data(tdata[0]), .tx_rdy(trdy[0]),
    .tx_ack(tack[0]), .grant_o(grant[0]), .busy(busy[0]), .frame_abort(abort[0]));

  tx_frame_arbiter #(.DATA_WIDTH(8), .SOURCES(3), .ARB_MODE(1), .HEADER_EN(0),
                     .HEADER_BASE(8'hA0), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst_n), .src_data(sd[1]), .src_rdy(srdy[1]), .src_eof(seof[1]),
    .src_ack(sack[1]), .src_en(sen[1]), .tx_data(tdata[1]), .tx_rdy(trdy[1]),
    .tx_ack(tack[1]), .grant_o(grant[1]), .busy(busy[1]), .frame_abort(abort[1]));

  // Sources: word = {source, words consumed}; ready while under budget; each budget
  // extension is one frame (eof on its last word) unless every word is a frame.
  int unsigned cons   [ND][S];
  int unsigned budget [ND][S];
  bit          one    [ND][S];
  bit          hold   [ND][S];

  initial for (int d = 0; d < ND; d++) for (int i = 0; i < S; i++) cons[d][i] = 0;

  always @(posedge clk)
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < S; i++)
        if (sack[d][i]) cons[d][i] <= cons[d][i] + 1;

  always_comb begin
    for (int d = 0; d < ND; d++) begin
      srdy[d] = '0;
      seof[d] = '0;
      sd[d]   = '0;
      for (int i = 0; i < S; i++) begin
        srdy[d][i]       = (cons[d][i] < budget[d][i]) && !hold[d][i];
        seof[d][i]       = one[d][i] || (cons[d][i] + 1 == budget[d][i]);
        sd[d][i*W +: W]  = {4'(i), 4'(cons[d][i])};
      end
    end
  end

  // Model: phase 0 = no owner, 1 = header pending, 2 = payload from owner.
  int ph [ND], own [ND], ptr [ND], stall [ND];
  bit mab [ND];

  function automatic int pick(logic [S-1:0] req, bit rr, int p);
    for (int k = 0; k < S; k++) begin
      int j;
      j = rr ? (p + k) % S : k;
      if (req[j]) return j;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < ND; d++) begin
        ph[d] <= 0; own[d] <= 0; ptr[d] <= 0; stall[d] <= 0; mab[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        mab[d] <= 1'b0;
        if (ph[d] == 0) begin
          if ((srdy[d] & sen[d]) != 0) begin
            own[d]   <= pick(srdy[d] & sen[d], d == 1, ptr[d]);
            ph[d]    <= (d == 0) ? 1 : 2;
            stall[d] <= 0;
          end
        end else if (ph[d] == 1) begin
          if (tack[d]) begin ph[d] <= 2; stall[d] <= 0; end
        end else if (srdy[d][own[d]]) begin
          stall[d] <= 0;
          if (tack[d] && seof[d][own[d]]) begin
            ph[d]  <= 0;
            ptr[d] <= (own[d] + 1) % S;
          end
        end else begin
          stall[d] <= stall[d] + 1;
          if (stall[d] + 1 >= TO) begin
            ph[d]  <= 0;
            mab[d] <= 1'b1;
            ptr[d] <= (own[d] + 1) % S;
          end
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] xlog_a[$], xlog_b[$];
  logic [2:0] glog_b[$];
  logic [S-1:0] pg [ND];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_dut(input int d);
    string p;
    logic [S-1:0] eg, es;
    logic [W-1:0] ed;
    logic er;
    p  = (d == 0) ? "A" : "B";
    eg = (ph[d] != 0) ? 3'(3'b001 << own[d]) : 3'b000;
    er = (ph[d] == 1) ? 1'b1 : (ph[d] == 2) ? srdy[d][own[d]] : 1'b0;
    ed = (ph[d] == 1) ? 8'hA0 + 8'(own[d]) : (ph[d] == 2) ? sd[d][own[d]*W +: W] : 8'h00;
    es = (ph[d] == 2 && tack[d] && srdy[d][own[d]]) ? 3'(3'b001 << own[d]) : 3'b000;
    chk({p, ".grant"},   32'(grant[d]), 32'(eg));
    chk({p, ".busy"},    32'(busy[d]),  32'(ph[d] != 0));
    chk({p, ".abort"},   32'(abort[d]), 32'(mab[d]));
    chk({p, ".tx_rdy"},  32'(trdy[d]),  32'(er));
    chk({p, ".tx_data"}, 32'(tdata[d]), 32'(ed));
    chk({p, ".src_ack"}, 32'(sack[d]),  32'(es));
  endtask

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check_dut(d);
      if (rst_n && trdy[d] && tack[d]) begin
        if (d == 0) xlog_a.push_back(tdata[d]);
        else        xlog_b.push_back(tdata[d]);
      end
      if (d == 1 && grant[d] != 0 && pg[d] == 0) glog_b.push_back(grant[d]);
      pg[d] = grant[d];
    end
    @(posedge clk);
    #1;
  endtask

  logic [7:0] t1e [6] = '{8'hA0, 8'h00, 8'h01, 8'hA2, 8'h20, 8'h21};
  logic [2:0] t2e [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      sen[d] = 3'b111; tack[d] = 1'b1; pg[d] = '0;
      for (int i = 0; i < S; i++) begin
        budget[d][i] = 0; one[d][i] = 1'b0; hold[d][i] = 1'b0;
      end
    end
    tick(); tick();
    chk("reset.grant",   32'(grant[0]), 32'h0);
    chk("reset.tx_data", 32'(tdata[0]), 32'h0);
    chk("reset.tx_rdy",  32'(trdy[1]),  32'h0);
    chk("reset.busy",    32'(busy[1]),  32'h0);
    rst_n = 1'b1;
    tick();

    // Fixed priority, sources 0 and 2 each with a 2-word frame
    budget[0][0] = 2; budget[0][2] = 2;
    repeat (10) tick();
    chk("t1.count", 32'(xlog_a.size()), 32'd6);
    for (int k = 0; k < 6 && k < xlog_a.size(); k++) chk("t1.word", 32'(xlog_a[k]), 32'(t1e[k]));

    // tx backpressure mid-payload
    budget[0][1] = 3;
    tick(); tick(); tick();
    tack[0] = 1'b0;
    repeat (5) begin
      tick();
      chk("t3.data",  32'(tdata[0]), 32'h11);
      chk("t3.rdy",   32'(trdy[0]),  32'h1);
      chk("t3.ack",   32'(sack[0]),  32'h0);
      chk("t3.abort", 32'(abort[0]), 32'h0);
    end
    tack[0] = 1'b1;
    repeat (4) tick();

    // Stall timeout: source 0 goes silent after one payload word
    budget[0][0] = cons[0][0] + 3;
    budget[0][2] = cons[0][2] + 2;
    tick(); tick(); tick();
    hold[0][0] = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      n++;
      if (abort[0]) break;
    end
    chk("t4.abort_delay", 32'(n), 32'd16);
    chk("t4.idle_grant",  32'(grant[0]), 32'h0);
    tick();
    chk("t4.next_grant",  32'(grant[0]), 32'b100);
    repeat (5) tick();
    budget[0][0] = cons[0][0]; hold[0][0] = 1'b0;
    tick();

    // Round-robin, all sources ready with single-word frames
    for (int i = 0; i < S; i++) begin one[1][i] = 1'b1; budget[1][i] = 2; end
    repeat (16) tick();
    chk("t2.count", 32'(glog_b.size()), 32'd6);
    for (int k = 0; k < 6 && k < glog_b.size(); k++) chk("t2.order", 32'(glog_b[k]), 32'(t2e[k]));

    // Source 0 masked, no header word
    sen[1] = 3'b110;
    for (int i = 0; i < S; i++) budget[1][i] = 3;
    repeat (6) tick();
    chk("t5.first_grant", (glog_b.size() > 6) ? 32'(glog_b[6]) : 32'hFFFF, 32'b010);
    chk("t5.first_word",  (xlog_b.size() > 6) ? 32'(xlog_b[6]) : 32'hFFFF, 32'h12);
    chk("t5.masked",      32'(cons[1][0]), 32'd2);
    sen[1] = 3'b111;
    repeat (3) tick();

    // Reset mid-frame; round-robin restarts from source 0
    one[1][2] = 1'b0;
    budget[1][2] = cons[1][2] + 4;
    tick(); tick();
    chk("t6.pre_grant", 32'(grant[1]), 32'b100);
    rst_n = 1'b0;
    #1;
    chk("t6.grant",   32'(grant[1]), 32'h0);
    chk("t6.tx_rdy",  32'(trdy[1]),  32'h0);
    chk("t6.tx_data", 32'(tdata[1]), 32'h0);
    chk("t6.busy",    32'(busy[1]),  32'h0);
    chk("t6.ack",     32'(sack[1]),  32'h0);
    tick();
    budget[1][0] = cons[1][0] + 1;
    budget[1][1] = cons[1][1] + 1;
    rst_n = 1'b1;
    tick();
    chk("t6.rr_restart", 32'(grant[1]), 32'b001);
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
